rv_mem_arbiter: RTL and testbench
=================================

Name: rv_mem_arbiter

Overview:
- Shares one single-port synchronous block RAM between the rv_core instruction-fetch port and data port.
- Decodes the LED I/O register at data address bit 12.
- Sits between rv_core and the imem/dmem storage in the top-level synth wrapper, so the core runs from one unified RAM.
- Uses round-robin arbitration and a fixed 3-cycle req-to-ack handshake per access.

Parameters:
- ADDR_W, 10, RAM word-address width (depth 2**ADDR_W words of 32 bits).
- LED_W, 3, width of the LED output register.
- IO_BIT, 12, byte-address bit that selects the I/O region when set.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- i_req  input  1  instruction read request; held until i_ack.
- i_addr  input  32  instruction byte address.
- i_rdata  output  32  instruction read data; valid while i_ack=1.
- i_ack  output  1  one-cycle completion pulse.
- d_req  input  1  data request; held until d_ack.
- d_we  input  1  1=write, 0=read.
- d_addr  input  32  data byte address.
- d_wdata  input  32  write data.
- d_rdata  output  32  data read data; valid while d_ack=1.
- d_ack  output  1  one-cycle completion pulse.
- mem_en  output  1  RAM enable.
- mem_we  output  1  RAM write enable.
- mem_addr  output  ADDR_W  RAM word address.
- mem_wdata  output  32  RAM write data.
- mem_rdata  input  32  RAM read data, registered by the RAM, valid the cycle after mem_en.
- leds  output  LED_W  LED register.

Behaviour:
- Reset is synchronous on clk, active-high.
  - state=IDLE; i_ack=d_ack=0; i_rdata=d_rdata=0; leds=0.
  - prio=INSTR: the instruction port wins the first tie.
  - Reset mid-access aborts the access; no ack is issued and leds are not updated.
- FSM states are IDLE, WAIT and ACK.
- IDLE, grant selection:
  - Only one request: that port is granted.
  - Both requests: the port named by prio is granted, and prio flips to the other port.
  - A single uncontested grant sets prio to the other port.
- IDLE, in the grant cycle N:
  - mem_en=1 combinationally.
  - mem_addr = addr[ADDR_W+1:2] of the granted port. Address bits [1:0] are ignored; addresses above the RAM alias.
  - Next state is WAIT.
  - With no request, mem_en=mem_we=0 and the FSM stays in IDLE.
- Data write (grant cycle N):
  - IO bit clear: mem_we=1 and mem_wdata=d_wdata in cycle N.
  - IO bit set: mem_en=mem_we=0 and leds<=d_wdata[LED_W-1:0] at the end of cycle N; the RAM is untouched.
- Data read with IO bit set: mem_en=0; d_rdata returns {zero-extend, leds}.
- WAIT (cycle N+1):
  - Latch mem_rdata (or the IO value) into the granted port's rdata.
  - Set that port's ack<=1.
  - Next state is ACK.
- ACK (cycle N+2):
  - Exactly one ack is high for one cycle.
  - rdata holds its value until the next access to the same port.
  - Next state is IDLE.
- Latency: ack is high in cycle N+2 after the grant in cycle N. A requester whose req was high since before cycle N sees its ack 3 cycles after req.
- Requester rule: req (and addr/we/wdata) stay stable until ack, and req drops at the clock edge that samples ack=1.
  - Because IDLE follows ACK, a still-high req in IDLE is treated as a new request.
- Requests arriving in WAIT or ACK are not lost; they are evaluated in the next IDLE.
- Maximum throughput is one access per 3 cycles. Under continuous contention, grants alternate I, D, I, D.
- i_ack and d_ack are never high in the same cycle.
- mem_we is never 1 while i_req alone is granted.

Test Plan:
- Fetch: RAM[5]=0x00000013; i_req=1, i_addr=0x14 -> mem_en=1 and mem_addr=5 in the grant cycle; i_ack=1 with i_rdata=0x00000013 two cycles later; d_ack stays 0.
- Write then read: d_we=1, d_addr=0x40, d_wdata=0xCAFEBABE -> mem_we=1, mem_addr=16, d_ack after 2 cycles; then a read of 0x40 -> d_rdata=0xCAFEBABE.
- Contention: i_req and d_req raised together after reset and held (re-raised after each ack) -> grant order I, D, I, D; acks alternate with 3-cycle spacing; never both acks in one cycle.
- LED I/O: write d_addr=0x1000, d_wdata=0x5 -> leds=3'b101 at the end of the grant cycle, mem_we=0, RAM[0] unchanged; read 0x1000 -> d_rdata=0x00000005.
- Reset mid-op: assert reset in WAIT of a data read -> the next cycle has state IDLE, no d_ack, leds=0; after release, a simultaneous request is granted to the instruction port first.
- Aliasing/alignment: a read of i_addr=0x1017 with ADDR_W=10 -> mem_addr=0x005 (bits [1:0] and bits above ADDR_W+1 ignored).

Source files
------------

// File: rtl/rv_mem_arbiter_if.sv
// Core-side bus of the unified memory arbiter: instruction fetch port and data port.
// The core drives the master modport; the arbiter takes the slave modport.
interface rv_mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        input  i_rdata, i_ack, d_rdata, d_ack
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        output i_rdata, i_ack, d_rdata, d_ack
    );
endinterface

// File: rtl/rv_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the
// instruction and data ports, with a LED register decoded at data address bit IO_BIT.
module rv_mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int LED_W  = 3,
    parameter int IO_BIT = 12
) (
    input  logic              clk,
    input  logic              reset,
    rv_mem_arbiter_if.slave   bus,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [LED_W-1:0]  leds
);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t             state_reg;
    logic               prio_d_reg;   // 1: data port wins the next tie
    logic               sel_d_reg;    // current access belongs to the data port
    logic               io_reg;       // current access targets the LED register
    logic [LED_W-1:0]   leds_reg;
    logic [31:0]        i_rdata_reg;
    logic [31:0]        d_rdata_reg;
    logic               i_ack_reg;
    logic               d_ack_reg;

    logic idle;
    logic grant_i;
    logic grant_d;
    logic d_io;
    logic unused_addr_bits;

    assign idle    = (state_reg == IDLE);
    assign grant_i = idle && bus.i_req && (!bus.d_req || !prio_d_reg);
    assign grant_d = idle && bus.d_req && (!bus.i_req ||  prio_d_reg);
    assign d_io    = bus.d_addr[IO_BIT];

    // The RAM sees the request combinationally in the grant cycle; LED accesses bypass it.
    assign mem_en    = grant_i || (grant_d && !d_io);
    assign mem_we    = grant_d && !d_io && bus.d_we;
    assign mem_addr  = grant_d ? bus.d_addr[ADDR_W+1:2] : bus.i_addr[ADDR_W+1:2];
    assign mem_wdata = bus.d_wdata;

    assign bus.i_rdata = i_rdata_reg;
    assign bus.d_rdata = d_rdata_reg;
    assign bus.i_ack   = i_ack_reg;
    assign bus.d_ack   = d_ack_reg;
    assign leds        = leds_reg;

    // Byte-lane and high address bits alias by design.
    assign unused_addr_bits = ^{bus.i_addr[31:ADDR_W+2], bus.i_addr[1:0],
                                bus.d_addr[31:ADDR_W+2], bus.d_addr[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            prio_d_reg  <= 1'b0;
            sel_d_reg   <= 1'b0;
            io_reg      <= 1'b0;
            leds_reg    <= '0;
            i_rdata_reg <= '0;
            d_rdata_reg <= '0;
            i_ack_reg   <= 1'b0;
            d_ack_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_i || grant_d) begin
                        state_reg  <= WAIT;
                        sel_d_reg  <= grant_d;
                        io_reg     <= grant_d && d_io;
                        prio_d_reg <= grant_i;
                        if (grant_d && d_io && bus.d_we) begin
                            leds_reg <= bus.d_wdata[LED_W-1:0];
                        end
                    end
                end
                WAIT: begin
                    state_reg <= ACK;
                    if (sel_d_reg) begin
                        d_rdata_reg <= io_reg ? {{(32-LED_W){1'b0}}, leds_reg} : mem_rdata;
                        d_ack_reg   <= 1'b1;
                    end else begin
                        i_rdata_reg <= mem_rdata;
                        i_ack_reg   <= 1'b1;
                    end
                end
                ACK: begin
                    state_reg <= IDLE;
                    i_ack_reg <= 1'b0;
                    d_ack_reg <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Bench for rv_mem_arbiter: directed scenarios plus random traffic from both ports,
// checked every cycle against a timeline model of grants, acks, RAM contents and LEDs.
module tb_rv_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [2:0]  leds;

    rv_mem_arbiter_if bus();

    rv_mem_arbiter #(.ADDR_W(10), .LED_W(3), .IO_BIT(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .leds      (leds)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] v;
        if (i == 5) return 32'h0000_0013;
        v = 32'(i) * 32'h9E37_79B1;
        return v ^ 32'h5A5A_0000;
    endfunction

    // Read-first single-port RAM, preloaded while reset is held.
    logic [31:0] ram [0:1023];
    int pre_idx = 0;
    always @(posedge clk) begin
        if (reset) begin
            if (pre_idx < 1024) begin
                ram[pre_idx] <= init_word(pre_idx);
                pre_idx      <= pre_idx + 1;
            end
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    int total = 0;
    int bad = 0;

    // Reference model state.
    logic [31:0] model_mem [0:1023];
    int          cyc = 0;
    int          free_at = 0;
    bit          prio_d = 1'b0;
    bit          pend_valid = 1'b0;
    bit          pend_d, pend_rd;
    int          pend_cyc;
    logic [31:0] pend_data;
    logic [2:0]  m_leds = '0;
    logic [31:0] m_i_rdata = '0;
    logic [31:0] m_d_rdata = '0;
    bit          m_d_known = 1'b1;
    logic [31:0] last_grant_addr;
    logic        last_grant_we, last_grant_en;
    bit          ack_log [$];
    int          ack_cyc [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checker_loop();
        bit          exp_i_ack, exp_d_ack, g_d, io, exp_en, exp_we;
        logic [9:0]  a;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                pend_valid = 1'b0;
                prio_d     = 1'b0;
                m_leds     = '0;
                m_i_rdata  = '0;
                m_d_rdata  = '0;
                m_d_known  = 1'b1;
                free_at    = cyc + 1;
            end else begin
                exp_i_ack = pend_valid && pend_cyc == cyc && !pend_d;
                exp_d_ack = pend_valid && pend_cyc == cyc &&  pend_d;
                if (exp_i_ack) m_i_rdata = pend_data;
                if (exp_d_ack) begin
                    m_d_known = pend_rd;
                    if (pend_rd) m_d_rdata = pend_data;
                end
                if (pend_valid && pend_cyc == cyc) pend_valid = 1'b0;
                chk("i_ack", 32'(bus.i_ack), 32'(exp_i_ack));
                chk("d_ack", 32'(bus.d_ack), 32'(exp_d_ack));
                chk("i_rdata", bus.i_rdata, m_i_rdata);
                if (m_d_known) chk("d_rdata", bus.d_rdata, m_d_rdata);
                chk("leds", 32'(leds), 32'(m_leds));
                if (bus.i_ack) begin ack_log.push_back(1'b0); ack_cyc.push_back(cyc); end
                if (bus.d_ack) begin ack_log.push_back(1'b1); ack_cyc.push_back(cyc); end

                if (cyc >= free_at && (bus.i_req || bus.d_req)) begin
                    g_d    = bus.d_req && (!bus.i_req || prio_d);
                    prio_d = !g_d;
                    if (g_d) begin
                        a       = bus.d_addr[11:2];
                        io      = bus.d_addr[12];
                        exp_en  = !io;
                        exp_we  = !io && bus.d_we;
                        pend_rd = !bus.d_we;
                        pend_data = io ? {29'b0, m_leds} : model_mem[a];
                    end else begin
                        a       = bus.i_addr[11:2];
                        exp_en  = 1'b1;
                        exp_we  = 1'b0;
                        pend_rd = 1'b1;
                        pend_data = model_mem[a];
                    end
                    chk("mem_en_grant", 32'(mem_en), 32'(exp_en));
                    chk("mem_we_grant", 32'(mem_we), 32'(exp_we));
                    if (exp_en) chk("mem_addr", 32'(mem_addr), 32'(a));
                    if (exp_we) chk("mem_wdata", mem_wdata, bus.d_wdata);
                    last_grant_addr = 32'(mem_addr);
                    last_grant_we   = mem_we;
                    last_grant_en   = mem_en;
                    pend_valid = 1'b1;
                    pend_d     = g_d;
                    pend_cyc   = cyc + 2;
                    free_at    = cyc + 3;
                    if (g_d && bus.d_we) begin
                        if (io) m_leds = bus.d_wdata[2:0];
                        else    model_mem[a] = bus.d_wdata;
                    end
                end else begin
                    chk("mem_en_idle", 32'(mem_en), 32'd0);
                    chk("mem_we_idle", 32'(mem_we), 32'd0);
                end
            end
        end
    endtask

    // Called just after a rising edge; returns just after the edge that samples ack.
    task automatic i_access(input logic [31:0] addr, output logic [31:0] data);
        int n = 0;
        bus.i_req  = 1'b1;
        bus.i_addr = addr;
        do begin @(negedge clk); n++; end while (!bus.i_ack && n < 20);
        if (!bus.i_ack) chk("i_ack_timeout", 32'd0, 32'd1);
        data = bus.i_rdata;
        @(posedge clk); #1;
        bus.i_req = 1'b0;
    endtask

    task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] data);
        int n = 0;
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        do begin @(negedge clk); n++; end while (!bus.d_ack && n < 20);
        if (!bus.d_ack) chk("d_ack_timeout", 32'd0, 32'd1);
        data = bus.d_rdata;
        @(posedge clk); #1;
        bus.d_req = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, rd2;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        for (int i = 0; i < 1024; i++) model_mem[i] = init_word(i);
        fork checker_loop(); join_none

        repeat (1030) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_i_ack", 32'(bus.i_ack), 32'd0);
        chk("rst_d_ack", 32'(bus.d_ack), 32'd0);
        chk("rst_leds", 32'(leds), 32'd0);
        chk("rst_d_rdata", bus.d_rdata, 32'd0);
        @(posedge clk); #1;

        i_access(32'h14, rd);
        $display("fetch 0x14 -> %h", rd);
        chk("fetch_addr", last_grant_addr, 32'd5);
        chk("fetch_data", rd, 32'h0000_0013);

        i_access(32'h1017, rd);
        $display("fetch 0x1017 -> %h", rd);
        chk("alias_addr", last_grant_addr, 32'd5);
        chk("alias_data", rd, 32'h0000_0013);

        d_access(1'b1, 32'h40, 32'hCAFE_BABE, rd);
        $display("write 0x40 <- cafebabe");
        chk("wr_addr", last_grant_addr, 32'd16);
        chk("wr_we", 32'(last_grant_we), 32'd1);
        d_access(1'b0, 32'h40, 32'h0, rd);
        $display("read 0x40 -> %h", rd);
        chk("rd_back", rd, 32'hCAFE_BABE);

        d_access(1'b1, 32'h1000, 32'h5, rd);
        $display("led write 5 -> leds=%b", leds);
        chk("led_val", 32'(leds), 32'd5);
        chk("led_mem_en", 32'(last_grant_en), 32'd0);
        d_access(1'b0, 32'h0, 32'h0, rd);
        $display("read 0x0 -> %h", rd);
        chk("ram0_kept", rd, init_word(0));
        d_access(1'b0, 32'h1000, 32'h0, rd);
        $display("led read -> %h", rd);
        chk("led_read", rd, 32'h0000_0005);

        // Abort a data read in its WAIT cycle.
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h80;
        @(posedge clk); #1;
        reset = 1'b1; bus.d_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_d_ack", 32'(bus.d_ack), 32'd0);
        chk("abort_leds", 32'(leds), 32'd0);
        @(negedge clk);
        chk("abort_d_ack2", 32'(bus.d_ack), 32'd0);
        $display("reset mid-read: d_ack=%b leds=%b", bus.d_ack, leds);
        @(posedge clk); #1;

        // Leave prio on the data port, then reset must hand the first tie to instructions.
        i_access(32'h0, rd);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        ack_log.delete(); ack_cyc.delete();
        fork
            i_access(32'h14, rd);
            d_access(1'b0, 32'h40, 32'h0, rd2);
        join
        $display("post-reset tie: first ack port=%0d", ack_log.size() > 0 ? int'(ack_log[0]) : -1);
        chk("tie_count", 32'(ack_log.size()), 32'd2);
        if (ack_log.size() > 0) chk("tie_first_i", 32'(ack_log[0]), 32'd0);

        ack_log.delete(); ack_cyc.delete();
        fork
            repeat (4) i_access(32'h14, rd);
            repeat (4) d_access(1'b0, 32'h40, 32'h0, rd2);
        join
        chk("cont_count", 32'(ack_log.size()), 32'd8);
        for (int k = 0; k < ack_log.size() && k < 8; k++) begin
            $display("contention ack %0d port=%0d cycle=%0d", k, ack_log[k], ack_cyc[k]);
            chk("cont_order", 32'(ack_log[k]), 32'(k % 2));
            if (k > 0) chk("cont_spacing", 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd3);
        end

        fork
            begin
                logic [31:0] a, r;
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    a = $urandom;
                    a[11:2] = 10'($urandom_range(0, 15));
                    i_access(a, r);
                    $display("rand i %0d addr=%h data=%h", k, a, r);
                end
            end
            begin
                logic [31:0] a, w, r;
                logic        we;
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    a = $urandom;
                    a[11:2] = 10'($urandom_range(0, 15));
                    a[12] = ($urandom_range(0, 3) == 0);
                    w = $urandom;
                    we = 1'($urandom_range(0, 1));
                    d_access(we, a, w, r);
                    $display("rand d %0d we=%0d addr=%h wdata=%h rdata=%h", k, we, a, w, r);
                end
            end
        join

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
